// File: rtl/event_notify_sched_pkg.sv
// Shared defaults and helpers for the event notification scheduler.
package event_notify_sched_pkg;
    localparam int EVS_MAX_EVENTS   = 16;
    localparam int EVS_EVENT_COUNT  = 16;
    localparam int EVS_EVENT_BITS   = 4;
    localparam int EVS_AUX_WIDTH    = 2;
    localparam int EVS_MAX_INFLIGHT = 2;

    function automatic int evs_next_idx(input int idx, input int count);
        return (idx + 1 >= count) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/event_notify_sched_if.sv
// Event-number offer stream and confirmation return path.
interface event_notify_sched_if #(
    parameter int EVENT_COUNT_BITS = event_notify_sched_pkg::EVS_EVENT_BITS,
    parameter int AUX_WIDTH        = event_notify_sched_pkg::EVS_AUX_WIDTH
) ();
    logic [AUX_WIDTH-1:0]        m_evno_user;
    logic [EVENT_COUNT_BITS-1:0] m_evno_data;
    logic                        m_evno_valid;
    logic                        m_evno_ready;
    logic [EVENT_COUNT_BITS-1:0] s_cnfno_data;
    logic                        s_cnfno_valid;
    logic                        s_cnfno_ready;

    modport master (
        output m_evno_user, m_evno_data, m_evno_valid, s_cnfno_ready,
        input  m_evno_ready, s_cnfno_data, s_cnfno_valid
    );
    modport slave (
        input  m_evno_user, m_evno_data, m_evno_valid, s_cnfno_ready,
        output m_evno_ready, s_cnfno_data, s_cnfno_valid
    );
endinterface

// File: rtl/event_notify_sched_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i, wrapping at N-1.
module event_notify_sched_rr_pick #(
    parameter int N = event_notify_sched_pkg::EVS_MAX_EVENTS,
    parameter int W = event_notify_sched_pkg::EVS_EVENT_BITS
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [W-1:0] gnt_o,
    output logic         any_o
);
    logic [W:0]   sum;
    logic [W-1:0] idx;

    always_comb begin
        gnt_o = '0;
        any_o = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_i} + (W + 1)'(k);
            idx = (sum >= (W + 1)'(N)) ? W'(sum - (W + 1)'(N)) : sum[W-1:0];
            if (!any_o && req_i[idx]) begin
                any_o = 1'b1;
                gnt_o = idx;
            end
        end
    end
endmodule

// File: rtl/event_notify_sched.sv
// Coalesces event pulses into pending bits and issues them round-robin, tracking in-flight
// events until confirmed. Define EVENT_SCHED_MASK_EN to add the cfg_mask_i source enable.
module event_notify_sched #(
    parameter int EVENT_COUNT      = event_notify_sched_pkg::EVS_EVENT_COUNT,
    parameter int EVENT_COUNT_BITS = event_notify_sched_pkg::EVS_EVENT_BITS,
    parameter int AUX_WIDTH        = event_notify_sched_pkg::EVS_AUX_WIDTH,
    parameter int MAX_INFLIGHT     = event_notify_sched_pkg::EVS_MAX_INFLIGHT
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [EVENT_COUNT-1:0]                ev_pulse_i,
    input  logic [EVENT_COUNT-1:0][AUX_WIDTH-1:0] ev_aux_i,
`ifdef EVENT_SCHED_MASK_EN
    input  logic [EVENT_COUNT-1:0]                cfg_mask_i,
`endif
    input  logic                                  st_clr_i,
    event_notify_sched_if.master                  bus,
    output logic [EVENT_COUNT-1:0]                st_pending_o,
    output logic [EVENT_COUNT-1:0]                st_inflight_o,
    output logic [EVENT_COUNT-1:0]                st_ovf_o,
    output logic                                  st_spurious_o
);
    import event_notify_sched_pkg::*;

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic [EVENT_COUNT-1:0]      pending_q, pending_d, inflight_q, inflight_d, ovf_q, ovf_d;
    logic [EVENT_COUNT-1:0]      enable, hs_vec, cnf_vec;
    logic [EVENT_COUNT_BITS-1:0] ptr_q, ptr_d, evno_q, evno_d, pick_idx;
    logic [AUX_WIDTH-1:0]        user_q, user_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        valid_q, valid_d, spurious_q, spurious_d;
    logic                        pick_any, offer, hs, cnf_in_range, cnf_hit;

`ifdef EVENT_SCHED_MASK_EN
    assign enable = cfg_mask_i;
`else
    assign enable = '1;
`endif

    event_notify_sched_rr_pick #(.N(EVENT_COUNT), .W(EVENT_COUNT_BITS)) u_pick (
        .req_i (pending_q & ~inflight_q & enable),
        .ptr_i (ptr_q),
        .gnt_o (pick_idx),
        .any_o (pick_any)
    );

    // New offers are only made from an empty output register, which leaves one idle
    // cycle after every handshake.
    assign offer        = !valid_q && pick_any && (cnt_q < CNT_W'(MAX_INFLIGHT));
    assign hs           = valid_q && bus.m_evno_ready;
    assign cnf_in_range = {1'b0, bus.s_cnfno_data} < (EVENT_COUNT_BITS + 1)'(EVENT_COUNT);
    assign cnf_hit      = bus.s_cnfno_valid && cnf_in_range && inflight_q[bus.s_cnfno_data];
    assign hs_vec       = hs ? (EVENT_COUNT'(1) << evno_q) : '0;
    assign cnf_vec      = cnf_hit ? (EVENT_COUNT'(1) << bus.s_cnfno_data) : '0;

    always_comb begin
        pending_d  = (pending_q & ~hs_vec) | ev_pulse_i;
        ovf_d      = (ovf_q & ~{EVENT_COUNT{st_clr_i}}) | (ev_pulse_i & pending_q & ~hs_vec);
        inflight_d = (inflight_q & ~cnf_vec) | hs_vec;
        spurious_d = (spurious_q && !st_clr_i) || (bus.s_cnfno_valid && !cnf_hit);
        cnt_d      = cnt_q + CNT_W'(hs) - CNT_W'(cnf_hit);
        valid_d    = valid_q;
        evno_d     = evno_q;
        user_d     = user_q;
        ptr_d      = ptr_q;
        if (hs) valid_d = 1'b0;
        if (offer) begin
            valid_d = 1'b1;
            evno_d  = pick_idx;
            user_d  = ev_aux_i[pick_idx];
            ptr_d   = EVENT_COUNT_BITS'(evs_next_idx(int'(pick_idx), EVENT_COUNT));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= '0;
            inflight_q <= '0;
            ovf_q      <= '0;
            spurious_q <= 1'b0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            evno_q     <= '0;
            user_q     <= '0;
            ptr_q      <= '0;
        end else begin
            pending_q  <= pending_d;
            inflight_q <= inflight_d;
            ovf_q      <= ovf_d;
            spurious_q <= spurious_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            evno_q     <= evno_d;
            user_q     <= user_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.m_evno_valid  = valid_q;
    assign bus.m_evno_data   = evno_q;
    assign bus.m_evno_user   = user_q;
    assign bus.s_cnfno_ready = 1'b1;
    assign st_pending_o      = pending_q;
    assign st_inflight_o     = inflight_q;
    assign st_ovf_o          = ovf_q;
    assign st_spurious_o     = spurious_q;
endmodule
